// File: rtl/traffic_pkg.sv
// Shared types for the four-way traffic signal: phase encoding, lamp codes,
// and the mapping from phase to the timing duration that governs it.
// Pure declarations; no latency and no flow control.
package traffic_pkg;

  // All nine phases keep a fixed encoding whether or not ALL_RED is built in.
  typedef enum logic [3:0] {
    N_GREEN  = 4'd0,
    N_YELLOW = 4'd1,
    S_GREEN  = 4'd2,
    S_YELLOW = 4'd3,
    E_GREEN  = 4'd4,
    E_YELLOW = 4'd5,
    W_GREEN  = 4'd6,
    W_YELLOW = 4'd7,
    ALL_RED  = 4'd8
  } phase_e;

  typedef enum logic [1:0] {
    DUR_GREEN   = 2'd0,
    DUR_YELLOW  = 2'd1,
    DUR_ALL_RED = 2'd2
  } dur_sel_e;

  // Lamp field layout is {red, yellow, green}.
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  // Selects which tick budget applies to a given phase.
  function automatic dur_sel_e phase_dur_sel(input phase_e ph);
    dur_sel_e sel;
    case (ph)
      N_GREEN, S_GREEN, E_GREEN, W_GREEN:     sel = DUR_GREEN;
      N_YELLOW, S_YELLOW, E_YELLOW, W_YELLOW: sel = DUR_YELLOW;
      default:                                sel = DUR_ALL_RED;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/top_traffic_signal_tick_gen.sv
// Clock-enable generator: one-cycle tick every TICK_DIV clk cycles.
// Tick is combinational from the counter; first tick TICK_DIV cycles after reset.
// No backpressure; free-running once out of reset.
module tick_gen #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  // Keep a 1-bit counter when TICK_DIV is 1 so the vector never collapses to zero width.
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign tick   = w_wrap;

  // Count 0..TICK_DIV-1 and wrap; reset restarts the division window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/top_traffic_signal.sv
// Four-way traffic signal: round-robin N,S,E,W, each green then yellow.
// Lamps are a Moore decode of the phase register; change the cycle after a phase edge.
// No backpressure. Optional macro ALL_RED_EN inserts an all-red clearance after each yellow.
module top_traffic_signal
  import traffic_pkg::*;
#(
  parameter int TICK_DIV      = 1000000,
  parameter int GREEN_TICKS   = 10,
  parameter int YELLOW_TICKS  = 3,
  parameter int ALL_RED_TICKS = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] north_dir,
  output logic [2:0] south_dir,
  output logic [2:0] east_dir,
  output logic [2:0] west_dir
);

  logic        w_tick;
  phase_e      r_state;
  phase_e      w_next;
  phase_e      w_follow;
  logic [31:0] r_phase_cnt;
  logic [31:0] w_dur;
  logic        w_last;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Tick budget of the current phase.
  always_comb begin
    w_dur = 32'(GREEN_TICKS);
    case (phase_dur_sel(r_state))
      DUR_GREEN:   w_dur = 32'(GREEN_TICKS);
      DUR_YELLOW:  w_dur = 32'(YELLOW_TICKS);
      default:     w_dur = 32'(ALL_RED_TICKS);
    endcase
  end

  assign w_last = (r_phase_cnt == (w_dur - 32'd1));

  // Green that follows the yellow currently showing (wraps W back to N).
  always_comb begin
    w_follow = N_GREEN;
    case (r_state)
      N_YELLOW: w_follow = S_GREEN;
      S_YELLOW: w_follow = E_GREEN;
      E_YELLOW: w_follow = W_GREEN;
      default:  w_follow = N_GREEN;
    endcase
  end

`ifdef ALL_RED_EN
  phase_e r_ret_green;

  // Remember which green to resume once the shared ALL_RED phase expires.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ret_green <= S_GREEN;
    end else if (w_tick && w_last && (phase_dur_sel(r_state) == DUR_YELLOW)) begin
      r_ret_green <= w_follow;
    end
  end
`endif

  // Phase sequencing: green -> yellow -> (all-red) -> next approach's green.
  always_comb begin
    w_next = r_state;
    case (r_state)
      N_GREEN:  w_next = N_YELLOW;
      S_GREEN:  w_next = S_YELLOW;
      E_GREEN:  w_next = E_YELLOW;
      W_GREEN:  w_next = W_YELLOW;
`ifdef ALL_RED_EN
      N_YELLOW, S_YELLOW, E_YELLOW, W_YELLOW: w_next = ALL_RED;
      ALL_RED:  w_next = r_ret_green;
`else
      N_YELLOW, S_YELLOW, E_YELLOW, W_YELLOW: w_next = w_follow;
`endif
      default:  w_next = N_GREEN;
    endcase
  end

  // Phase register and tick counter within the phase; reset beats any pending tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= N_GREEN;
      r_phase_cnt <= '0;
    end else if (w_tick) begin
      if (w_last) begin
        r_state     <= w_next;
        r_phase_cnt <= '0;
      end else begin
        r_phase_cnt <= r_phase_cnt + 32'd1;
      end
    end
  end

  // Lamp decode: only the active approach leaves red.
  always_comb begin
    north_dir = LAMP_RED;
    south_dir = LAMP_RED;
    east_dir  = LAMP_RED;
    west_dir  = LAMP_RED;
    case (r_state)
      N_GREEN:  north_dir = LAMP_GREEN;
      N_YELLOW: north_dir = LAMP_YELLOW;
      S_GREEN:  south_dir = LAMP_GREEN;
      S_YELLOW: south_dir = LAMP_YELLOW;
      E_GREEN:  east_dir  = LAMP_GREEN;
      E_YELLOW: east_dir  = LAMP_YELLOW;
      W_GREEN:  west_dir  = LAMP_GREEN;
      W_YELLOW: west_dir  = LAMP_YELLOW;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_top_traffic_signal.sv
// Directed bench for top_traffic_signal: reset, rotation timing, mid-phase
// reset, held reset, and a fast 1/1/1 instance; honours ALL_RED_EN.
module tb_top_traffic_signal;

  localparam int D = 4;
  localparam int G = 3;
  localparam int Y = 2;
`ifdef ALL_RED_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif
  localparam int SEG  = (G + Y + AR) * D;
  localparam int ROT  = 4 * SEG;
  localparam int FROT = 4 * (1 + 1 + AR);

  localparam logic [11:0] L_NG  = 12'b001_100_100_100;
  localparam logic [11:0] L_NY  = 12'b010_100_100_100;
  localparam logic [11:0] L_SG  = 12'b100_001_100_100;
  localparam logic [11:0] L_EY  = 12'b100_100_010_100;
  localparam logic [11:0] L_ALL = 12'b100_100_100_100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       f_reset;
  logic [2:0] n_dir, s_dir, e_dir, w_dir;
  logic [2:0] fn_dir, fs_dir, fe_dir, fw_dir;
  logic [11:0] main_l;
  logic [11:0] fast_l;

  assign main_l = {n_dir, s_dir, e_dir, w_dir};
  assign fast_l = {fn_dir, fs_dir, fe_dir, fw_dir};

  top_traffic_signal #(
    .TICK_DIV(D), .GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALL_RED_TICKS(1)
  ) dut (
    .clk(clk), .reset(reset),
    .north_dir(n_dir), .south_dir(s_dir), .east_dir(e_dir), .west_dir(w_dir)
  );

  top_traffic_signal #(
    .TICK_DIV(1), .GREEN_TICKS(1), .YELLOW_TICKS(1), .ALL_RED_TICKS(1)
  ) dut_fast (
    .clk(clk), .reset(f_reset),
    .north_dir(fn_dir), .south_dir(fs_dir), .east_dir(fe_dir), .west_dir(fw_dir)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int k_main   = 0;

  // Expected lamps k cycles after the reset edge, from the timing rules alone.
  function automatic logic [11:0] model(input int k, input int d, input int g, input int y);
    int seg, m, dir, w;
    logic [2:0]  act;
    logic [11:0] r;
    seg = (g + y + AR) * d;
    m   = k % (4 * seg);
    dir = m / seg;
    w   = m % seg;
    if (w < g * d)            act = 3'b001;
    else if (w < (g + y) * d) act = 3'b010;
    else                      act = 3'b100;
    r = L_ALL;
    case (dir)
      0:       r[11:9] = act;
      1:       r[8:6]  = act;
      2:       r[5:3]  = act;
      default: r[2:0]  = act;
    endcase
    return r;
  endfunction

  // One-hot lamps on every approach and at most one approach off red.
  function automatic logic legal(input logic [11:0] l);
    logic       ok;
    int         nonred;
    logic [2:0] f;
    ok = 1'b1;
    nonred = 0;
    for (int i = 0; i < 4; i++) begin
      f = l[i*3 +: 3];
      if (!(f === 3'b100 || f === 3'b010 || f === 3'b001)) ok = 1'b0;
      if (f !== 3'b100) nonred++;
    end
    return ok && (nonred <= 1);
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare the main instance against the model for n cycles, advancing k_main.
  task automatic run_main(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s k=%0d", nm, k_main), main_l, model(k_main, D, G, Y));
      chk($sformatf("%s_legal k=%0d", nm, k_main), {11'd0, legal(main_l)}, 12'd1);
      step();
      k_main++;
    end
  endtask

  initial begin
    reset   = 1'b0;
    f_reset = 1'b0;
    step();
    step();

    // Reset then release: 12 cycles green, 8 yellow, then south.
    reset = 1'b1;
    step();
    reset  = 1'b0;
    k_main = 0;
    chk("reset_n_green", main_l, L_NG);
    run_main(12, "first_green");
    chk("n_yellow_at_12", main_l, L_NY);
    run_main(8, "n_yellow");
`ifdef ALL_RED_EN
    chk("all_red_at_20", main_l, L_ALL);
    run_main(4, "all_red");
    chk("s_green_at_24", main_l, L_SG);
`else
    chk("s_green_at_20", main_l, L_SG);
`endif
    // Full rotation back to north green.
    run_main(ROT - k_main, "rotation");
    chk("n_green_after_rotation", main_l, L_NG);

    // Reset in the middle of E_YELLOW.
    run_main(2 * SEG + G * D + 2, "to_e_yellow");
    chk("e_yellow_before_reset", main_l, L_EY);
    reset = 1'b1;
    step();
    reset  = 1'b0;
    k_main = 0;
    chk("mid_reset_n_green", main_l, L_NG);
    run_main(12, "post_mid_reset");
    chk("mid_reset_n_yellow_at_12", main_l, L_NY);

    // Reset held for 20 cycles freezes north green.
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("held_reset c=%0d", i), main_l, L_NG);
    end
    reset  = 1'b0;
    k_main = 0;
    run_main(12, "after_held");
    chk("held_n_yellow_at_12", main_l, L_NY);
    run_main(8, "after_held_yellow");
`ifdef ALL_RED_EN
    chk("held_all_red_at_20", main_l, L_ALL);
`else
    chk("held_s_green_at_20", main_l, L_SG);
`endif

    // Fast instance: a new phase every cycle.
    f_reset = 1'b1;
    step();
    f_reset = 1'b0;
    chk("fast_k0", fast_l, L_NG);
    step();
    chk("fast_k1", fast_l, L_NY);
    step();
`ifdef ALL_RED_EN
    chk("fast_k2", fast_l, L_ALL);
`else
    chk("fast_k2", fast_l, L_SG);
`endif
    for (int k = 2; k < 2 * FROT; k++) begin
      chk($sformatf("fast k=%0d", k), fast_l, model(k, 1, 1, 1));
      chk($sformatf("fast_legal k=%0d", k), {11'd0, legal(fast_l)}, 12'd1);
      if (k == FROT) chk("fast_rotation", fast_l, L_NG);
      step();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/top_traffic_signal.md
Name: top_traffic_signal

Overview:
- Four-way traffic signal controller.
- Grants right-of-way to one approach at a time in fixed round-robin order: north, south, east, west.
- Each approach runs green, then yellow, then red while the others run.
- Top-level block: contains a tick (clock-enable) generator and the phase FSM, and drives four 3-bit lamp outputs directly.

Parameters:
- TICK_DIV, default 1000000: clk cycles per timing tick; legal range >= 1.
- GREEN_TICKS, default 10: ticks spent in each green phase; legal range >= 1.
- YELLOW_TICKS, default 3: ticks spent in each yellow phase; legal range >= 1.
- ALL_RED_TICKS, default 1: ticks per all-red clearance phase; legal range >= 1; used only with ALL_RED_EN.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- north_dir  output  3  north lamps {red,yellow,green}.
- south_dir  output  3  south lamps {red,yellow,green}.
- east_dir  output  3  east lamps {red,yellow,green}.
- west_dir  output  3  west lamps {red,yellow,green}.

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- Lamp encoding is one-hot:
  - RED = 3'b100
  - YELLOW = 3'b010
  - GREEN = 3'b001
  - No other value is ever driven after reset.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick = 1 for exactly one cycle when count == TICK_DIV-1.
  - With TICK_DIV = 1, tick is high every cycle.
- Phase counter counts ticks within the current state.
  - On a tick where phase count == duration-1, the FSM advances and the phase counter clears.
  - Otherwise the phase counter increments on each tick.
  - Result: each state lasts exactly duration*TICK_DIV cycles.
- FSM states, in order, wrapping after W_YELLOW back to N_GREEN:
  - N_GREEN, N_YELLOW, S_GREEN, S_YELLOW, E_GREEN, E_YELLOW, W_GREEN, W_YELLOW.
  - Green states use duration GREEN_TICKS.
  - Yellow states use duration YELLOW_TICKS.
- Output decode (Moore, combinational from the state register):
  - The active approach shows GREEN or YELLOW according to the state.
  - All other approaches show RED.
  - Invariant: at most one output is non-RED in any cycle.
- Reset:
  - Any rising edge with reset = 1 forces state = N_GREEN, tick counter = 0, phase counter = 0.
  - In the cycle after that edge: north_dir = 001; south_dir, east_dir and west_dir = 100.
  - Reset wins over a simultaneous tick or state transition.
  - Reset asserted mid-phase (e.g. during E_YELLOW) immediately restarts a full N_GREEN phase.
  - Holding reset high freezes the block in N_GREEN with counters at 0.
- First green after reset release lasts exactly GREEN_TICKS*TICK_DIV cycles.
- Full rotation lasts 4*(GREEN_TICKS+YELLOW_TICKS)*TICK_DIV cycles.
- Outputs are undefined (X) until the first reset edge; the bench must apply reset before checking.

Optional Feature:
- Macro: ALL_RED_EN.
- When defined:
  - An ALL_RED clearance state is inserted after every yellow state, before the next green.
  - ALL_RED lasts ALL_RED_TICKS ticks; all four outputs = 100 during it.
  - Rotation becomes 4*(GREEN_TICKS+YELLOW_TICKS+ALL_RED_TICKS)*TICK_DIV cycles.
  - Reset still lands in N_GREEN.
- When undefined:
  - No ALL_RED state exists; yellow goes directly to the next green.
  - ALL_RED_TICKS is ignored.

Decomposition:
- Package traffic_pkg holds:
  - phase_e enum: the eight states plus ALL_RED, encoded even when unused.
  - Lamp constants LAMP_RED, LAMP_YELLOW, LAMP_GREEN (3-bit).
  - A function mapping phase_e to a duration selector.
- One sub-module, tick_gen:
  - Parameter TICK_DIV.
  - Ports clk, reset, tick.
  - Instantiated once in top_traffic_signal.
- The FSM, phase counter and output decode live in the top module.

Test Plan:
All scenarios use TICK_DIV=4, GREEN_TICKS=3, YELLOW_TICKS=2, ALL_RED_EN undefined, unless stated.
- Reset then release:
  - Cycle after the reset edge: N=001, S=E=W=100.
  - N stays 001 for exactly 12 cycles, then N=010 for 8 cycles, then N=100 and S=001.
- Full rotation:
  - Order is N_G, N_Y, S_G, S_Y, E_G, E_Y, W_G, W_Y.
  - N returns to 001 exactly 80 cycles after reset release.
  - Check the one-non-red invariant every cycle.
- Reset mid-operation:
  - Assert reset for 1 cycle during E_YELLOW.
  - Next cycle: N=001, others 100; the new N_GREEN lasts a full 12 cycles.
- Reset held for 20 cycles:
  - Outputs remain N=001, others 100, throughout.
  - After release, timing matches the first scenario.
- TICK_DIV=1, GREEN_TICKS=1, YELLOW_TICKS=1:
  - State changes every cycle.
  - Rotation = 8 cycles.
  - Legal encodings only.
- ALL_RED_EN defined, ALL_RED_TICKS=1:
  - After N_YELLOW, all four outputs = 100 for 4 cycles, then S=001.
  - Rotation = 96 cycles.
